op_decode_seq: RTL
==================

Name: op_decode_seq

Overview:
- Parametrised, registered instruction decoder and execute sequencer for the CPU control unit.
- Accepts an instruction word over a valid/ready handshake and checks its prefix field.
- Holds a one-hot decode vector and a step counter for the datapath until the datapath signals completion.
- Flags illegal prefixes and execution timeouts; sits between the fetch logic and the datapath control-signal generator.

Parameters:
- OP_W, 4, opcode field width (IR low bits); one-hot width is 2**OP_W.
- PREFIX_W, 4, prefix field width (IR high bits); IR_W = PREFIX_W+OP_W (localparam).
- PREFIX_VAL, 0, prefix value that marks a legal instruction.
- MAX_STEPS, 8, maximum execute cycles per instruction, >=2; STEP_W = clog2(MAX_STEPS) (localparam).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- FULL_RESET  input  1  synchronous, active-high reset.
- IR  input  IR_W  instruction word; prefix = IR[IR_W-1:OP_W], opcode = IR[OP_W-1:0].
- IR_VALID  input  1  fetch presents a valid IR.
- IR_READY  output  1  block can accept IR this cycle (combinational).
- EXEC_DONE  input  1  datapath finished the current instruction.
- DEC  output  2**OP_W  registered one-hot decode; bit k = opcode k.
- DEC_VALID  output  1  DEC/OPCODE/TSTEP meaningful.
- OPCODE  output  OP_W  registered opcode of the current instruction.
- TSTEP  output  STEP_W  execute step counter, 0 on first execute cycle.
- ILLEGAL  output  1  one-cycle pulse: the accepted IR had a bad prefix.
- TIMEOUT  output  1  one-cycle pulse: execution exceeded MAX_STEPS.
- BUSY  output  1  state != IDLE.

Behaviour:
- Reset: one clock, synchronous, active-high; FULL_RESET is sampled at the CLK rising edge only.
- Reset state: state=IDLE, DEC=0, DEC_VALID=0, OPCODE=0, TSTEP=0, ILLEGAL=0, TIMEOUT=0, BUSY=0.
- Reset priority: FULL_RESET overrides everything, including mid-EXEC (instruction abandoned, no TIMEOUT/ILLEGAL pulse) and a same-cycle handshake.
- States: IDLE, EXEC, ERR.
- IR_READY = (state==IDLE) | (state==EXEC & EXEC_DONE); forced 0 while FULL_RESET=1.
- Accept = IR_VALID & IR_READY. On accept, the prefix check (IR[IR_W-1:OP_W]==PREFIX_VAL) selects the next state.
- Legal accept -> EXEC next cycle: DEC=1<<opcode, OPCODE=opcode, TSTEP=0, DEC_VALID=1. Latency is 1 cycle from accept to DEC_VALID.
- Illegal accept -> ERR next cycle: DEC=0, DEC_VALID=0, ILLEGAL=1 for that cycle only, then IDLE.
- EXEC, EXEC_DONE=1: instruction retires.
  - If a new accept happens the same cycle, go straight to EXEC with the new decode and TSTEP=0 (back-to-back, no bubble); an illegal new IR goes to ERR.
  - Otherwise go to IDLE with DEC=0, DEC_VALID=0.
- EXEC, EXEC_DONE=0, TSTEP<MAX_STEPS-1: TSTEP increments; DEC/OPCODE held.
- EXEC, EXEC_DONE=0, TSTEP==MAX_STEPS-1: next cycle IDLE, TIMEOUT=1 for one cycle, DEC cleared.
- Same cycle at TSTEP==MAX_STEPS-1 with EXEC_DONE=1: done wins, no TIMEOUT.
- ERR: IR_READY=0; returns to IDLE unconditionally.
- IR_VALID with IR_READY=0 has no effect; fetch must hold IR.
- DEC is exactly one-hot whenever DEC_VALID=1 and all-zero otherwise. ILLEGAL and TIMEOUT are never high together.
- EXEC_DONE is ignored outside EXEC.

Test Plan:
- Reset/idle: assert FULL_RESET 2 cycles with IR_VALID=1, IR=8'h05 -> all outputs 0, no accept; release -> IR_READY=1, BUSY=0.
- Legal decode: defaults, IR=8'h0A, IR_VALID pulse; EXEC_DONE at 3rd EXEC cycle -> next cycle DEC=16'h0400, OPCODE=4'hA, DEC_VALID=1; TSTEP 0,1,2; then IDLE, DEC=0.
- Illegal prefix: IR=8'h31 accepted -> next cycle ILLEGAL=1, DEC=0, DEC_VALID=0; IDLE the following cycle.
- Back-to-back: in EXEC of 8'h01 assert EXEC_DONE with IR_VALID=1, IR=8'h0F -> IR_READY=1 that cycle; next cycle DEC=16'h8000, TSTEP=0, no idle gap.
- Timeout: IR=8'h02, EXEC_DONE held 0 -> TSTEP counts 0..7, then TIMEOUT=1 one cycle, IDLE, DEC=0.
- Done at last step and mid-EXEC reset:
  - EXEC_DONE=1 at TSTEP=7 -> no TIMEOUT.
  - FULL_RESET at TSTEP=3 -> next cycle all outputs 0, state IDLE, no pulses.

Source files
------------

// File: rtl/op_decode_seq.sv
// Registered instruction decoder and execute sequencer: accepts an IR over valid/ready,
// checks its prefix, and holds a one-hot decode plus step counter until the datapath retires it.
module op_decode_seq #(
  parameter int OP_W       = 4,
  parameter int PREFIX_W   = 4,
  parameter int PREFIX_VAL = 0,
  parameter int MAX_STEPS  = 8
) (
  input  logic                         CLK,
  input  logic                         FULL_RESET,
  input  logic [PREFIX_W+OP_W-1:0]     IR,
  input  logic                         IR_VALID,
  output logic                         IR_READY,
  input  logic                         EXEC_DONE,
  output logic [(2**OP_W)-1:0]         DEC,
  output logic                         DEC_VALID,
  output logic [OP_W-1:0]              OPCODE,
  output logic [$clog2(MAX_STEPS)-1:0] TSTEP,
  output logic                         ILLEGAL,
  output logic                         TIMEOUT,
  output logic                         BUSY
);

  localparam int IR_W   = PREFIX_W + OP_W;
  localparam int DEC_W  = 2 ** OP_W;
  localparam int STEP_W = $clog2(MAX_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  function automatic logic prefix_ok(input logic [IR_W-1:0] ir);
    return ir[IR_W-1:OP_W] == PREFIX_W'(PREFIX_VAL);
  endfunction

  function automatic logic [DEC_W-1:0] one_hot(input logic [OP_W-1:0] op);
    logic [DEC_W-1:0] v;
    v     = '0;
    v[op] = 1'b1;
    return v;
  endfunction

  // A retiring instruction frees the slot in the same cycle, so fetch can issue back-to-back.
  assign IR_READY = !FULL_RESET && ((state == IDLE) || ((state == EXEC) && EXEC_DONE));
  assign accept   = IR_VALID && IR_READY;
  assign BUSY     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (FULL_RESET) begin
      state     <= IDLE;
      DEC       <= '0;
      DEC_VALID <= 1'b0;
      OPCODE    <= '0;
      TSTEP     <= '0;
      ILLEGAL   <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      ILLEGAL <= 1'b0;
      TIMEOUT <= 1'b0;
      if (accept) begin
        TSTEP <= '0;
        if (prefix_ok(IR)) begin
          state     <= EXEC;
          DEC       <= one_hot(IR[OP_W-1:0]);
          OPCODE    <= IR[OP_W-1:0];
          DEC_VALID <= 1'b1;
        end else begin
          state     <= ERR;
          DEC       <= '0;
          DEC_VALID <= 1'b0;
          ILLEGAL   <= 1'b1;
        end
      end else begin
        case (state)
          EXEC: begin
            // Completion takes precedence over the step limit on the final step.
            if (EXEC_DONE) begin
              state     <= IDLE;
              DEC       <= '0;
              DEC_VALID <= 1'b0;
              TSTEP     <= '0;
            end else if (TSTEP == LAST_STEP) begin
              state     <= IDLE;
              DEC       <= '0;
              DEC_VALID <= 1'b0;
              TSTEP     <= '0;
              TIMEOUT   <= 1'b1;
            end else begin
              TSTEP <= TSTEP + STEP_W'(1);
            end
          end
          ERR:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_pulse_excl: assert property (@(posedge CLK) disable iff (FULL_RESET)
    !(ILLEGAL && TIMEOUT));
  a_dec_onehot: assert property (@(posedge CLK) disable iff (FULL_RESET)
    DEC_VALID |-> $onehot(DEC));
  a_dec_clear: assert property (@(posedge CLK) disable iff (FULL_RESET)
    !DEC_VALID |-> (DEC == '0));

endmodule
